// File: rtl/renkon_pkg.sv
// -----------------------------------------------------------------------------
// renkon_pkg
//   Shared constants and types for the renkon core convolution scheduler.
//   DWIDTH : pixel/accumulator data width used by the datapath
//   LWIDTH : width of size, count and coordinate fields
//   FSIZE  : filter edge; the adder tree is FSIZE*FSIZE = 25 inputs wide
//   D_CONV : fixed latency of the convolution adder tree, in cycles
// -----------------------------------------------------------------------------
package renkon_pkg;

    localparam int DWIDTH = 16;
    localparam int LWIDTH = 10;
    localparam int FSIZE  = 5;
    localparam int D_CONV = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Tag that travels alongside each issued window through the tree latency.
    typedef struct packed {
        logic              first_ch;
        logic              last_ch;
        logic [LWIDTH-1:0] row;
        logic [LWIDTH-1:0] col;
    } dl_tag_t;

endpackage

// File: rtl/renkon_sched_delay.sv
// -----------------------------------------------------------------------------
// renkon_sched_delay
//   Free-running valid/tag shift register that mirrors the adder-tree latency.
//   An entry presented on in_valid/in_tag appears on out_valid/out_tag exactly
//   DEPTH cycles later.
//   clk       : clock, rising edge
//   xrst      : asynchronous reset, active low
//   in_valid  : entry valid at the head of the line
//   in_tag    : WIDTH-bit tag carried with the entry
//   out_valid : valid at the tail (tap DEPTH)
//   out_tag   : tag at the tail
//   any_valid : at least one stage holds a valid entry
// -----------------------------------------------------------------------------
module renkon_sched_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_tag,
    output logic             any_valid
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] tag_q [DEPTH];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            valid_q <= '0;
            // NOTE: the tag stages are reset as well; the line is only a few
            // entries deep, and clean tags keep the coordinate outputs at 0
            // after reset instead of carrying stale values.
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its predecessor held before this edge, so order of the
            // statements below does not matter.
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/renkon_conv_sched.sv
// -----------------------------------------------------------------------------
// renkon_conv_sched
//   Scheduler for the 5x5 convolution adder tree of one renkon core. On req it
//   walks every output position (row outer, col) and every input channel
//   (inner), issuing one window per unstalled cycle. Each issue is tracked
//   through the tree latency to drive the channel accumulator and to flag
//   finished output pixels; ack reports the end of the layer.
//   clk       : clock, rising edge
//   xrst      : asynchronous reset, active low
//   req       : start pulse, sampled only when idle
//   img_size  : input map edge (square), sampled with req
//   n_in      : input channel count, sampled with req
//   stall     : downstream not ready; suppresses issue only
//   busy      : high from accepted req until ack
//   ack       : one-cycle layer-done pulse
//   win_en    : window strobe to buffer/tree
//   win_row   : window top-left row
//   win_col   : window top-left col
//   win_ch    : input channel of the window
//   acc_clear : accumulator load (first channel of a position)
//   acc_en    : accumulator add (tree output valid)
//   out_valid : accumulator holds a finished output pixel
//   out_row   : row of the out_valid pixel
//   out_col   : col of the out_valid pixel
// -----------------------------------------------------------------------------
module renkon_conv_sched
    import renkon_pkg::*;
(
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [LWIDTH-1:0] img_size,
    input  logic [LWIDTH-1:0] n_in,
    input  logic              stall,
    output logic              busy,
    output logic              ack,
    output logic              win_en,
    output logic [LWIDTH-1:0] win_row,
    output logic [LWIDTH-1:0] win_col,
    output logic [LWIDTH-1:0] win_ch,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              out_valid,
    output logic [LWIDTH-1:0] out_row,
    output logic [LWIDTH-1:0] out_col
);

    localparam logic [LWIDTH-1:0] FSIZE_W = LWIDTH'(FSIZE);
    localparam logic [LWIDTH-1:0] ONE_W   = LWIDTH'(1);

    state_t            state;
    logic [LWIDTH-1:0] pos_last;   // osize - 1
    logic [LWIDTH-1:0] ch_last;    // n_in - 1
    logic [LWIDTH-1:0] row;
    logic [LWIDTH-1:0] col;
    logic [LWIDTH-1:0] ch;
    logic              win_first;
    logic              win_last;

    dl_tag_t           win_tag;
    dl_tag_t           dl_tag;
    logic              dl_valid;
    logic              dl_any;

    assign win_tag = '{first_ch: win_first, last_ch: win_last,
                       row: win_row, col: win_col};

    // Mirrors the adder tree: the registered issue enters here and emerges
    // D_CONV cycles later, when the tree output for that window is valid.
    renkon_sched_delay #(
        .WIDTH ($bits(dl_tag_t)),
        .DEPTH (D_CONV)
    ) u_delay (
        .clk       (clk),
        .xrst      (xrst),
        .in_valid  (win_en),
        .in_tag    (win_tag),
        .out_valid (dl_valid),
        .out_tag   (dl_tag),
        .any_valid (dl_any)
    );

    assign acc_en    = dl_valid;
    assign acc_clear = dl_valid & dl_tag.first_ch;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ack       <= 1'b0;
            win_en    <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            win_ch    <= '0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            pos_last  <= '0;
            ch_last   <= '0;
            row       <= '0;
            col       <= '0;
            ch        <= '0;
        end else begin
            // Pulse outputs default low; only the states below raise them.
            ack    <= 1'b0;
            win_en <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A req landing in the ack cycle belongs to the layer
                    // that just finished and is dropped.
                    if (req && !ack) begin
                        busy     <= 1'b1;
                        row      <= '0;
                        col      <= '0;
                        ch       <= '0;
                        pos_last <= img_size - FSIZE_W;
                        ch_last  <= n_in - ONE_W;
                        if (img_size < FSIZE_W || n_in == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (!stall) begin
                        win_en    <= 1'b1;
                        win_row   <= row;
                        win_col   <= col;
                        win_ch    <= ch;
                        win_first <= (ch == '0);
                        win_last  <= (ch == ch_last);
                        if (ch == ch_last) begin
                            ch <= '0;
                            if (col == pos_last) begin
                                col <= '0;
                                if (row == pos_last) begin
                                    row   <= '0;
                                    state <= S_DRAIN;
                                end else begin
                                    row <= row + ONE_W;
                                end
                            end else begin
                                col <= col + ONE_W;
                            end
                        end else begin
                            ch <= ch + ONE_W;
                        end
                    end
                end

                S_DRAIN: begin
                    // Once the issue register and the whole delay line are
                    // empty, the last tail entry has been turned into the
                    // out_valid that is on the output this cycle.
                    if (!win_en && !dl_any) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // A finished pixel is flagged one cycle after its last channel is added.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= dl_valid & dl_tag.last_ch;
            if (dl_valid && dl_tag.last_ch) begin
                out_row <= dl_tag.row;
                out_col <= dl_tag.col;
            end
        end
    end

endmodule

// File: tb/tb_renkon_conv_sched.sv
// -----------------------------------------------------------------------------
// tb_renkon_conv_sched
//   Self-checking bench for renkon_conv_sched. A monitor logs every strobe
//   with its cycle number; a reference model builds the expected schedule
//   from the loop order, stall window and tree latency, and the logs are
//   compared against it after each layer.
// -----------------------------------------------------------------------------
module tb_renkon_conv_sched;
    import renkon_pkg::*;

    logic              clk = 1'b0;
    logic              xrst = 1'b0;
    logic              req = 1'b0;
    logic              stall = 1'b0;
    logic [LWIDTH-1:0] img_size = '0;
    logic [LWIDTH-1:0] n_in = '0;
    logic              busy, ack, win_en, acc_clear, acc_en, out_valid;
    logic [LWIDTH-1:0] win_row, win_col, win_ch, out_row, out_col;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int row;
        int col;
        int ch;
    } ev_t;

    ev_t win_q[$], out_q[$], exp_win[$], exp_out[$];
    int  clr_q[$], en_q[$], ack_q[$], exp_clr[$], exp_en[$];
    int  busy_cnt = 0;

    renkon_conv_sched dut (
        .clk       (clk),
        .xrst      (xrst),
        .req       (req),
        .img_size  (img_size),
        .n_in      (n_in),
        .stall     (stall),
        .busy      (busy),
        .ack       (ack),
        .win_en    (win_en),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_ch    (win_ch),
        .acc_clear (acc_clear),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (xrst) begin
            if (win_en)    win_q.push_back('{cyc, int'(win_row), int'(win_col), int'(win_ch)});
            if (acc_clear) clr_q.push_back(cyc);
            if (acc_en)    en_q.push_back(cyc);
            if (out_valid) out_q.push_back('{cyc, int'(out_row), int'(out_col), 0});
            if (ack)       ack_q.push_back(cyc);
            if (busy)      busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        win_q.delete(); out_q.delete(); clr_q.delete();
        en_q.delete();  ack_q.delete();
        busy_cnt = 0;
    endtask

    // One layer: req at cycle r, optional stall window [r+s0, r+s0+slen),
    // optional extra req while busy and optional req coincident with ack.
    task automatic run_layer(input string tag, input int img, input int nin,
                             input int s0, input int slen,
                             input bit extra_req, input bit coin_req,
                             output int ack_off);
        int  r, os, p, a_exp, n;
        bit  seen_ack;

        clear_logs();
        exp_win.delete(); exp_out.delete(); exp_clr.delete(); exp_en.delete();

        @(negedge clk);
        r        = cyc;
        req      = 1'b1;
        img_size = LWIDTH'(img);
        n_in     = LWIDTH'(nin);

        // Reference schedule: first issue slot is two cycles after the req
        // cycle; a slot is lost whenever stall was high in the cycle before.
        os = (img >= FSIZE) ? img - FSIZE + 1 : 0;
        p  = r + 2;
        if (nin > 0) begin
            for (int rr = 0; rr < os; rr++)
                for (int cc = 0; cc < os; cc++)
                    for (int ch = 0; ch < nin; ch++) begin
                        while (p - 1 >= r + s0 && p - 1 < r + s0 + slen) p++;
                        exp_win.push_back('{p, rr, cc, ch});
                        exp_en.push_back(p + D_CONV);
                        if (ch == 0)       exp_clr.push_back(p + D_CONV);
                        if (ch == nin - 1) exp_out.push_back('{p + D_CONV + 1, rr, cc, 0});
                        p++;
                    end
        end
        a_exp = (exp_win.size() == 0) ? r + 2
                                      : exp_win[exp_win.size()-1].cyc + D_CONV + 3;

        seen_ack = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            req   = 1'b0;
            stall = (cyc >= r + s0 && cyc < r + s0 + slen);
            if (extra_req && cyc == r + 4) begin
                req      = 1'b1;
                img_size = LWIDTH'(5);
                n_in     = LWIDTH'(1);
            end
            if (ack) begin
                seen_ack = 1'b1;
                break;
            end
        end
        check({tag, " ack_seen"}, 64'(seen_ack), 64'd1);
        if (coin_req) begin
            req      = 1'b1;
            img_size = LWIDTH'(6);
            n_in     = LWIDTH'(1);
        end
        stall = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (D_CONV + 8) @(negedge clk);

        check({tag, " win_count"}, 64'(win_q.size()), 64'(exp_win.size()));
        n = (win_q.size() < exp_win.size()) ? win_q.size() : exp_win.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s win%0d_cyc", tag, i), 64'(win_q[i].cyc), 64'(exp_win[i].cyc));
            check($sformatf("%s win%0d_row", tag, i), 64'(win_q[i].row), 64'(exp_win[i].row));
            check($sformatf("%s win%0d_col", tag, i), 64'(win_q[i].col), 64'(exp_win[i].col));
            check($sformatf("%s win%0d_ch",  tag, i), 64'(win_q[i].ch),  64'(exp_win[i].ch));
        end
        check({tag, " en_count"}, 64'(en_q.size()), 64'(exp_en.size()));
        n = (en_q.size() < exp_en.size()) ? en_q.size() : exp_en.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s en%0d_cyc", tag, i), 64'(en_q[i]), 64'(exp_en[i]));
        check({tag, " clr_count"}, 64'(clr_q.size()), 64'(exp_clr.size()));
        n = (clr_q.size() < exp_clr.size()) ? clr_q.size() : exp_clr.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s clr%0d_cyc", tag, i), 64'(clr_q[i]), 64'(exp_clr[i]));
        check({tag, " out_count"}, 64'(out_q.size()), 64'(exp_out.size()));
        n = (out_q.size() < exp_out.size()) ? out_q.size() : exp_out.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s out%0d_cyc", tag, i), 64'(out_q[i].cyc), 64'(exp_out[i].cyc));
            check($sformatf("%s out%0d_row", tag, i), 64'(out_q[i].row), 64'(exp_out[i].row));
            check($sformatf("%s out%0d_col", tag, i), 64'(out_q[i].col), 64'(exp_out[i].col));
        end
        check({tag, " ack_count"}, 64'(ack_q.size()), 64'd1);
        ack_off = (ack_q.size() > 0) ? ack_q[0] - r : -1;
        check({tag, " ack_cyc"}, 64'(ack_off), 64'(a_exp - r));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(a_exp - r - 1));
    endtask

    initial begin
        int off, off_t2, off_t3;
        int img, nin, s0, slen;

        // Reset state, both during and right after reset.
        repeat (3) @(negedge clk);
        check("rst_outputs_held",
              {busy, ack, win_en, acc_clear, acc_en, out_valid,
               win_row, win_col, win_ch, out_row, out_col}, 64'd0);
        xrst = 1'b1;
        @(negedge clk);
        check("rst_outputs_released",
              {busy, ack, win_en, acc_clear, acc_en, out_valid,
               win_row, win_col, win_ch, out_row, out_col}, 64'd0);

        // Minimal 2x2 output, single channel.
        run_layer("t1", 6, 1, 0, 0, 1'b0, 1'b0, off);
        // 3x3 output, three channels.
        run_layer("t2", 7, 3, 0, 0, 1'b0, 1'b0, off_t2);
        // Same layer with a 4-cycle stall mid-run.
        run_layer("t3", 7, 3, 6, 4, 1'b0, 1'b0, off_t3);
        check("t3 ack_delay", 64'(off_t3 - off_t2), 64'd4);
        // Degenerate sizes: no issue, ack two cycles after req.
        run_layer("t4a", 4, 2, 0, 0, 1'b0, 1'b0, off);
        check("t4a ack_off", 64'(off), 64'd2);
        run_layer("t4b", 7, 0, 0, 0, 1'b0, 1'b0, off);
        check("t4b ack_off", 64'(off), 64'd2);
        // Extra req while busy and req coincident with ack are dropped.
        run_layer("t5", 6, 2, 0, 0, 1'b1, 1'b1, off);
        // Degenerate layer followed by a coincident req.
        run_layer("t5b", 3, 1, 0, 0, 1'b0, 1'b1, off);

        // Reset in the middle of a run.
        clear_logs();
        @(negedge clk);
        req = 1'b1; img_size = LWIDTH'(8); n_in = LWIDTH'(2);
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
        check("t6 busy_before_rst", 64'(busy), 64'd1);
        xrst = 1'b0;
        #1;
        check("t6 outputs_in_rst",
              {busy, ack, win_en, acc_clear, acc_en, out_valid,
               win_row, win_col, win_ch, out_row, out_col}, 64'd0);
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        clear_logs();
        repeat (D_CONV + 20) @(negedge clk);
        check("t6 no_ack_after_rst", 64'(ack_q.size()), 64'd0);
        check("t6 no_win_after_rst", 64'(win_q.size()), 64'd0);
        check("t6 no_out_after_rst", 64'(out_q.size()), 64'd0);
        run_layer("t6 restart", 6, 2, 0, 0, 1'b0, 1'b0, off);

        // Randomized layers.
        for (int t = 0; t < 8; t++) begin
            img  = int'($urandom_range(9, 3));
            nin  = int'($urandom_range(4, 0));
            s0   = int'($urandom_range(8, 2));
            slen = int'($urandom_range(5, 0));
            run_layer($sformatf("rnd%0d_i%0d_n%0d", t, img, nin), img, nin, s0, slen,
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), off);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
